register_file: RTL and testbench

//  Parametrised CPU register file, successor to the single 8-bit register_module.

---
 rtl/register_file.sv | 164 ++++++++++++++++
 tb/tb_register_file.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: parametrised CPU register file with two registered read
// ports, forwarding from the write port, and a shadow bank filled/drained
// one register per cycle by a small copy engine for context save/restore.
module register_file #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  save,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] data_out_a,
    output logic [DATA_WIDTH-1:0] data_out_b,
    input  logic                  ctx_save,
    input  logic                  ctx_restore,
    output logic                  busy,
    output logic                  wr_dropped
);

    localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [ADDR_WIDTH-1:0]   idx_next;
    logic                    busy_next;
    logic                    copy_save_c;
    logic                    copy_restore_c;
    logic                    wr_en_c;

    logic [DATA_WIDTH-1:0]   regs   [NUM_REGS];
    logic [DATA_WIDTH-1:0]   shadow [NUM_REGS];

    // Address is backed by real storage (in range and not the hardwired zero)
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < NUM_REGS_W) && !(ZERO_REG && (a == '0));
    endfunction

    // Architectural write accepted only while the copy engine is idle
    always_comb begin
        wr_en_c = save && !busy && addr_ok(wr_addr);
    end

    // Copy FSM state, index and busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            idx   <= idx_next;
            busy  <= busy_next;
        end
    end

    // Next-state: save wins over restore; both return to IDLE after the last index
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ctx_save) begin
                    next_state = SAVE;
                end else if (ctx_restore) begin
                    next_state = RESTORE;
                end
            end
            SAVE, RESTORE: begin
                if (idx == LAST_IDX) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Copy-engine controls: per-cycle copy strobes, index advance and busy update
    always_comb begin
        idx_next       = idx;
        busy_next      = busy;
        copy_save_c    = 1'b0;
        copy_restore_c = 1'b0;
        case (state)
            IDLE: begin
                if (ctx_save || ctx_restore) begin
                    idx_next  = '0;
                    busy_next = 1'b1;
                end
            end
            SAVE, RESTORE: begin
                copy_save_c    = (state == SAVE);
                copy_restore_c = (state == RESTORE);
                if (idx == LAST_IDX) begin
                    idx_next  = '0;
                    busy_next = 1'b0;
                end else begin
                    idx_next = idx + ADDR_WIDTH'(1);
                end
            end
            default: begin
                idx_next  = '0;
                busy_next = 1'b0;
            end
        endcase
    end

    // Register and shadow storage; restore never overlaps an accepted write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            if (copy_save_c) begin
                shadow[idx] <= regs[idx];
            end
            if (copy_restore_c && addr_ok(idx)) begin
                regs[idx] <= shadow[idx];
            end
            if (wr_en_c) begin
                regs[wr_addr] <= alu_out;
            end
        end
    end

    // Registered read ports with write-port forwarding and a rejected-write pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_a <= '0;
            data_out_b <= '0;
            wr_dropped <= 1'b0;
        end else begin
            if (wr_en_c && (wr_addr == rd_addr_a)) begin
                data_out_a <= alu_out;
            end else if (addr_ok(rd_addr_a)) begin
                data_out_a <= regs[rd_addr_a];
            end else begin
                data_out_a <= '0;
            end
            if (wr_en_c && (wr_addr == rd_addr_b)) begin
                data_out_b <= alu_out;
            end else if (addr_ok(rd_addr_b)) begin
                data_out_b <= regs[rd_addr_b];
            end else begin
                data_out_b <= '0;
            end
            wr_dropped <= save && busy;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed stimulus for register_file with a bank-level
// reference model checked on every cycle plus literal spot checks.
module tb_register_file;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 8;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          save;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] alu_out;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] data_out_a;
    logic [DW-1:0] data_out_b;
    logic          ctx_save;
    logic          ctx_restore;
    logic          busy;
    logic          wr_dropped;

    int n_cmp = 0;
    int n_bad = 0;

    register_file #(
        .DATA_WIDTH(DW),
        .NUM_REGS  (NR),
        .ADDR_WIDTH(AW),
        .ZERO_REG  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .save       (save),
        .wr_addr    (wr_addr),
        .alu_out    (alu_out),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .ctx_save   (ctx_save),
        .ctx_restore(ctx_restore),
        .busy       (busy),
        .wr_dropped (wr_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole bank as arrays; a copy is "remaining cycles" plus direction
    logic [DW-1:0] m_regs   [NR];
    logic [DW-1:0] m_shadow [NR];
    logic [DW-1:0] m_a, m_b;
    logic          m_busy, m_drop, m_valid = 1'b0, m_is_save;
    int            m_left;

    function automatic logic [DW-1:0] m_read(input int ra, input bit wv, input int wa, input logic [DW-1:0] wd);
        if (wv && wa == ra) return wd;
        if (ra == 0 || ra >= NR) return '0;
        return m_regs[ra];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i]   = '0;
                m_shadow[i] = '0;
            end
            m_a = '0; m_b = '0; m_busy = 1'b0; m_drop = 1'b0; m_left = 0; m_is_save = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            bit wv;
            int wa, k;
            wa = int'(wr_addr);
            wv = save && !m_busy && wa != 0 && wa < NR;
            m_a = m_read(int'(rd_addr_a), wv, wa, alu_out);
            m_b = m_read(int'(rd_addr_b), wv, wa, alu_out);
            m_drop = save && m_busy;
            if (m_busy) begin
                k = NR - m_left;
                if (m_is_save) m_shadow[k] = m_regs[k];
                else if (k != 0) m_regs[k] = m_shadow[k];
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end else if (ctx_save || ctx_restore) begin
                m_is_save = ctx_save;
                m_left = NR;
                m_busy = 1'b1;
            end
            if (wv) m_regs[wa] = alu_out;
        end
    end

    // Compare all outputs against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_a",    32'(data_out_a), 32'(m_a));
            check("model_b",    32'(data_out_b), 32'(m_b));
            check("model_busy", 32'(busy),       32'(m_busy));
            check("model_drop", 32'(wr_dropped), 32'(m_drop));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        save = 1'b1; wr_addr = AW'(a); alu_out = d;
        tick();
        save = 1'b0;
    endtask

    task automatic read_pair(input int a, input int b);
        rd_addr_a = AW'(a); rd_addr_b = AW'(b);
        tick();
    endtask

    // Counts busy cycles from the current one until busy falls, bounded
    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        if (n >= 20) check({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_copy(input bit s, input bit r);
        ctx_save = s; ctx_restore = r;
        tick();
        ctx_save = 1'b0; ctx_restore = 1'b0;
    endtask

    initial begin
        int n;
        logic [DW-1:0] exp;
        reset = 1'b1; save = 1'b0; wr_addr = '0; alu_out = '0;
        rd_addr_a = '0; rd_addr_b = '0; ctx_save = 1'b0; ctx_restore = 1'b0;
        tick(); tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_a",    32'(data_out_a), 32'd0);
        reset = 1'b0;

        // Basic writes and two-port reads
        do_write(3, 8'hAA);
        do_write(5, 8'h55);
        read_pair(3, 5);
        check("t1_a_r3", 32'(data_out_a), 32'hAA);
        check("t1_b_r5", 32'(data_out_b), 32'h55);
        for (int i = 0; i < NR; i++) begin
            if (i != 3 && i != 5) begin
                read_pair(i, i);
                check("t1_other_zero", 32'(data_out_a), 32'd0);
            end
        end

        // Forwarding on both ports, and r0 hardwired to zero
        rd_addr_a = 3'd2; rd_addr_b = 3'd2;
        do_write(2, 8'h3C);
        check("t2_fwd_a", 32'(data_out_a), 32'h3C);
        check("t2_fwd_b", 32'(data_out_b), 32'h3C);
        do_write(0, 8'hFF);
        read_pair(0, 0);
        check("t2_r0_zero", 32'(data_out_a), 32'd0);

        // Full save, wipe, full restore
        for (int i = 1; i < NR; i++) do_write(i, DW'(8'h11 * i));
        pulse_copy(1'b1, 1'b0);
        check("t3_busy_start", 32'(busy), 32'd1);
        wait_idle("t3_save", n);
        check("t3_save_len", 32'(n), 32'd8);
        for (int i = 1; i < NR; i++) do_write(i, 8'h00);
        read_pair(4, 7);
        check("t3_wiped", 32'(data_out_a), 32'd0);
        pulse_copy(1'b0, 1'b1);
        wait_idle("t3_restore", n);
        check("t3_restore_len", 32'(n), 32'd8);
        for (int i = 1; i < NR; i++) begin
            read_pair(i, NR - i);
            exp = DW'(8'h11 * i);
            check("t3_restored_a", 32'(data_out_a), 32'(exp));
        end

        // Write and restore request during a save copy are dropped
        pulse_copy(1'b1, 1'b0);
        tick(); tick();
        save = 1'b1; wr_addr = 3'd4; alu_out = 8'hEE; ctx_restore = 1'b1;
        tick();
        save = 1'b0; ctx_restore = 1'b0;
        check("t4_dropped", 32'(wr_dropped), 32'd1);
        tick();
        check("t4_drop_pulse", 32'(wr_dropped), 32'd0);
        wait_idle("t4_save", n);
        tick();
        check("t4_no_queued_restore", 32'(busy), 32'd0);
        read_pair(4, 4);
        check("t4_r4_unchanged", 32'(data_out_a), 32'h44);

        // Simultaneous save+restore performs a save
        do_write(1, 8'h99);
        pulse_copy(1'b1, 1'b1);
        wait_idle("t5_both", n);
        check("t5_len", 32'(n), 32'd8);
        read_pair(1, 2);
        check("t5_regs_kept", 32'(data_out_a), 32'h99);
        check("t5_r2_kept",   32'(data_out_b), 32'h22);
        do_write(1, 8'h00);
        pulse_copy(1'b0, 1'b1);
        wait_idle("t5_restore", n);
        read_pair(1, 1);
        check("t5_shadow_saved", 32'(data_out_a), 32'h99);

        // Reset in the middle of a restore clears everything
        rd_addr_a = 3'd5; rd_addr_b = 3'd6;
        pulse_copy(1'b0, 1'b1);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_busy_clear", 32'(busy), 32'd0);
        check("t6_out_a_clear", 32'(data_out_a), 32'd0);
        check("t6_out_b_clear", 32'(data_out_b), 32'd0);
        pulse_copy(1'b0, 1'b1);
        wait_idle("t6_restore", n);
        check("t6_restore_len", 32'(n), 32'd8);
        for (int i = 0; i < NR; i++) begin
            read_pair(i, i);
            check("t6_zero_restored", 32'(data_out_b), 32'd0);
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
